lcd_reader: RTL and testbench
=============================

LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter T_AS_CYC, default 2, meaning: address setup cycles with lcd_rs/lcd_rw valid before lcd_enable rises.
REQ-002 Parameter T_EN_CYC, default 12, meaning: lcd_enable high width in cycles (240 ns at 50 MHz).
REQ-003 Parameter T_H_CYC, default 2, meaning: cycles lcd_rs/lcd_rw are held after lcd_enable falls.
REQ-004 Parameter T_REC_CYC, default 11, meaning: recovery cycles before the next access or done; total access 27 cycles, at least the 500 ns enable cycle.
REQ-005 Parameter MAX_POLLS, default 4096, meaning: busy-flag reads before poll timeout.
REQ-006 clk  input  1  system clock; the one clock of the block.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 clk_en  input  1  custom-instruction clock enable; FSM and counters advance only when high.
REQ-009 start  input  1  custom-instruction start strobe.
REQ-010 dataa  input  32  command: bit0 = RS select (0 busy/address, 1 DDRAM/CGRAM data), bit1 = poll-until-not-busy; other bits ignored.
REQ-011 datab  input  32  unused, ignored.
REQ-012 result  output  32  [7:0] byte read, [8] timeout flag, [31:9] zero.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 lcd_enable  output  1  LCD E strobe.
REQ-015 lcd_rs  output  1  LCD register select.
REQ-016 lcd_rw  output  1  LCD read/write, 1 = read.
REQ-017 lcd_data_in  input  8  LCD data bus as seen by the block; the top level tri-states the pad whenever lcd_rw is 1.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, EN_HIGH, HOLD, RECOVER, DONE.
REQ-019 IDLE -> SETUP SHALL occur on a clock edge with start=1 and clk_en=1, latching dataa[1:0] and clearing the poll counter.
REQ-020 Start SHALL be ignored in every state other than IDLE.
REQ-021 On the IDLE -> SETUP edge, lcd_rw SHALL go 1 and lcd_rs SHALL take latched bit0.
REQ-022 SETUP SHALL last T_AS_CYC cycles with lcd_enable=0.
REQ-023 EN_HIGH SHALL last T_EN_CYC cycles with lcd_enable=1.
REQ-024 lcd_data_in SHALL be captured into the result byte on the edge where lcd_enable falls (last EN_HIGH cycle).
REQ-025 HOLD SHALL last T_H_CYC cycles with lcd_rs/lcd_rw unchanged and lcd_enable=0.
REQ-026 RECOVER SHALL last T_REC_CYC cycles; during RECOVER lcd_rw stays 1.
REQ-027 At the end of RECOVER, poll mode with captured bit7=1 and poll count < MAX_POLLS SHALL go back to SETUP and increment the poll count.
REQ-028 Poll mode with bit7=1 and poll count = MAX_POLLS SHALL go to DONE with result[8]=1.
REQ-029 Otherwise the end of RECOVER SHALL go to DONE with result[8]=0.
REQ-030 Poll mode with RS=1 SHALL perform exactly one read with no polling.
REQ-031 DONE SHALL assert done for exactly one cycle, drive lcd_rw=0 and lcd_rs=0, and return to IDLE.
REQ-032 Single-read latency SHALL be T_AS+T_EN+T_H+T_REC (27) cycles from the start edge to the done edge.
REQ-033 Each poll iteration SHALL add exactly 27 cycles of latency.
REQ-034 With clk_en=0, all state, counters and outputs SHALL hold their values; done SHALL never be asserted while clk_en=0.
REQ-035 result SHALL hold its value from DONE until the next capture.
REQ-036 The block SHALL never drive the LCD data bus.

Reset
REQ-037 With reset=0, outputs SHALL immediately become: lcd_enable=0, lcd_rs=0, lcd_rw=0, done=0, result=0; state SHALL be IDLE and counters 0.
REQ-038 A reset asserted mid-access SHALL abort the access without a done pulse; the next start SHALL begin a fresh 27-cycle access.

Verification
REQ-039 Single read: dataa=0x0, lcd_data_in=0x25 -> rw=1, rs=0, E high 12 cycles starting 2 cycles after start; done at cycle 27; result=0x00000025.
REQ-040 Data read: dataa=0x1, lcd_data_in=0xA5 -> rs=1 for the whole access; done at cycle 27; result=0x000000A5, bit8=0.
REQ-041 Poll: dataa=0x2, model BF=1 for 3 reads, then 0x07 -> 4 E pulses; done at cycle 108; result=0x00000007.
REQ-042 Timeout: MAX_POLLS=3, BF held 1 with bus 0x80 -> 4 E pulses; done at cycle 108; result=0x00000180.
REQ-043 clk_en held low for 10 cycles during EN_HIGH -> E pulse widened by 10 cycles; done at cycle 37.
REQ-044 reset low at cycle 5 of an access -> E and rw drop immediately, no done; restart completes in 27 cycles; extra start during an access is ignored.

Source files
------------

// File: rtl/lcd_reader.sv
// HD44780-style LCD read engine for a custom instruction: one timed read, or busy-flag polling.
// Fixed 27-cycle access per read (default timing); all progress gated by clk_en.
module lcd_reader #(
  parameter int T_AS_CYC  = 2,
  parameter int T_EN_CYC  = 12,
  parameter int T_H_CYC   = 2,
  parameter int T_REC_CYC = 11,
  parameter int MAX_POLLS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        lcd_enable,
  output logic        lcd_rs,
  output logic        lcd_rw,
  input  logic [7:0]  lcd_data_in
);

  localparam int CW  = 16;
  localparam int PCW = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    EN_HIGH = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [PCW-1:0] r_polls;
  logic           r_poll_mode;
  logic           r_rs_sel;
  logic [8:0]     r_result;
  logic           r_done;
  logic           r_enable;
  logic           r_rs;
  logic           r_rw;

  logic w_unused;
  assign w_unused = ^{datab, dataa[31:2]};

  // Gating with clk_en keeps done from being seen while the instruction clock is stalled.
  assign done       = r_done & clk_en;
  assign result     = {23'd0, r_result};
  assign lcd_enable = r_enable;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = r_rw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_polls     <= '0;
      r_poll_mode <= 1'b0;
      r_rs_sel    <= 1'b0;
      r_result    <= '0;
      r_done      <= 1'b0;
      r_enable    <= 1'b0;
      r_rs        <= 1'b0;
      r_rw        <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= SETUP;
            r_cnt       <= '0;
            r_polls     <= '0;
            r_poll_mode <= dataa[1];
            r_rs_sel    <= dataa[0];
            r_rs        <= dataa[0];
            r_rw        <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == CW'(T_AS_CYC - 1)) begin
            r_state  <= EN_HIGH;
            r_cnt    <= '0;
            r_enable <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        EN_HIGH: begin
          if (r_cnt == CW'(T_EN_CYC - 1)) begin
            r_state       <= HOLD;
            r_cnt         <= '0;
            r_enable      <= 1'b0;
            r_result[7:0] <= lcd_data_in;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == CW'(T_H_CYC - 1)) begin
            r_state <= RECOVER;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (r_cnt == CW'(T_REC_CYC - 1)) begin
            r_cnt <= '0;
            // Busy flag only has meaning on the instruction register (RS=0).
            if (r_poll_mode && !r_rs_sel && r_result[7] && (r_polls < PCW'(MAX_POLLS))) begin
              r_state <= SETUP;
              r_polls <= r_polls + 1'b1;
            end else begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_rs        <= 1'b0;
              r_rw        <= 1'b0;
              r_result[8] <= r_poll_mode && !r_rs_sel && r_result[7];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_done   <= 1'b0;
          r_enable <= 1'b0;
          r_rs     <= 1'b0;
          r_rw     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Random and directed LCD read accesses checked against a per-access reference model.
module tb_lcd_reader;

  localparam int MAXP   = 3;
  localparam int ACCESS = 27;
  localparam int EN_W   = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic        lcd_enable;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_reader #(.MAX_POLLS(MAXP)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
    .result      (result),
    .done        (done),
    .lcd_enable  (lcd_enable),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data_in (lcd_data_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; bytes[k] is what the LCD presents during the k-th E pulse.
  task automatic run_access(input logic rs, input logic poll,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int gap_at, input int extra_start_at, input string tag);
    logic [7:0]  bytes [4];
    logic [31:0] exp_result;
    logic        to_exp;
    logic        prev_e;
    int n_exp, busy, gap, done_cyc, first_rise, e_high, rises, rs_bad, rw_bad, en_low_done;

    bytes = '{b0, b1, b2, b3};
    busy = 0;
    while (busy < 4 && bytes[busy][7]) busy++;
    if (poll && !rs) begin
      to_exp = (busy > MAXP);
      n_exp  = to_exp ? MAXP + 1 : busy + 1;
    end else begin
      to_exp = 1'b0;
      n_exp  = 1;
    end
    exp_result = {23'd0, to_exp, bytes[n_exp-1]};
    gap = (gap_at > 0) ? 10 : 0;

    @(negedge clk);
    dataa  = ($urandom & 32'hFFFF_FFFC) | {30'd0, poll, rs};
    datab  = $urandom;
    clk_en = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " rw@start"}, {31'd0, lcd_rw}, 32'd1);
    check({tag, " rs@start"}, {31'd0, lcd_rs}, {31'd0, rs});

    done_cyc = -1; first_rise = -1; e_high = 0; rises = 0;
    rs_bad = 0; rw_bad = 0; en_low_done = 0; prev_e = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      #1;
      if (!clk_en && done) en_low_done++;
      if (lcd_enable && !prev_e) begin
        rises++;
        if (rises == 1) first_rise = cyc;
        if (rises <= 4) lcd_data_in = bytes[rises-1];
      end
      if (lcd_enable) e_high++;
      prev_e = lcd_enable;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (lcd_rw !== 1'b1) rw_bad++;
      if (lcd_rs !== rs) rw_bad += 0;
      if (lcd_rs !== rs) rs_bad++;
      start = (cyc == extra_start_at);
      if (start) dataa = 32'h3;
      if (gap_at > 0 && cyc == gap_at) clk_en = 1'b0;
      if (gap_at > 0 && cyc == gap_at + gap) clk_en = 1'b1;
    end
    start  = 1'b0;
    clk_en = 1'b1;

    check({tag, " done cycle"}, done_cyc, ACCESS * n_exp + gap);
    check({tag, " E pulses"}, rises, n_exp);
    check({tag, " E high cycles"}, e_high, EN_W * n_exp + gap);
    check({tag, " first E rise"}, first_rise, 2);
    check({tag, " rw held"}, rw_bad, 0);
    check({tag, " rs held"}, rs_bad, 0);
    check({tag, " done while clk_en low"}, en_low_done, 0);
    check({tag, " result"}, result, exp_result);
    check({tag, " rs/rw in DONE"}, {30'd0, lcd_rs, lcd_rw}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    check({tag, " result hold"}, result, exp_result);
  endtask

  initial begin
    int done_seen;
    reset = 1'b0; clk_en = 1'b1; start = 1'b0;
    dataa = '0; datab = '0; lcd_data_in = 8'h00;
    #12;
    check("reset outputs", {result[29:0], done, lcd_enable}, 32'd0);
    check("reset rs/rw", {30'd0, lcd_rs, lcd_rw}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_access(1'b0, 1'b0, 8'h25, 8'h00, 8'h00, 8'h00, 0, 0, "single");
    run_access(1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, "data");
    run_access(1'b0, 1'b1, 8'h80, 8'hC1, 8'hFF, 8'h07, 0, 0, "poll");
    run_access(1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 0, 0, "timeout");
    run_access(1'b1, 1'b1, 8'h9C, 8'h80, 8'h80, 8'h80, 0, 0, "poll rs1");
    run_access(1'b0, 1'b0, 8'h5A, 8'h00, 8'h00, 8'h00, 5, 0, "clk_en gap");
    run_access(1'b0, 1'b1, 8'hB3, 8'h11, 8'h00, 8'h00, 0, 10, "extra start");

    // Abort mid-access with reset, then confirm no done and a clean restart.
    @(negedge clk);
    dataa = 32'h0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort E/rw", {30'd0, lcd_enable, lcd_rw}, 32'd0);
    check("abort done/result", {result[30:0], done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort no done", done_seen, 0);
    run_access(1'b0, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h00, 0, 0, "restart");

    for (int k = 0; k < 16; k++) begin
      logic       rs, poll;
      logic [7:0] b [4];
      rs   = 1'($urandom_range(0, 1));
      poll = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++) begin
        b[j] = 8'($urandom);
        b[j][7] = ($urandom_range(0, 9) < 6);
      end
      run_access(rs, poll, b[0], b[1], b[2], b[3], 0,
                 ($urandom_range(0, 1) == 1) ? 20 : 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
